imem_refill_responder: RTL and testbench
========================================

Name: imem_refill_responder

Overview:
Memory-side responder for instruction-cache line refills. It accepts a line-fill request from the I-cache controller and reads the line from a word-organised instruction RAM. It returns the line as ICACHE_LINE_SIZE/4 sequential data beats under a valid/ready handshake. It also provides a simple preload write port, used by the testbench or boot loader to fill the RAM.

Parameters:
MEM_WORDS, IMEM_SIZE (1024), depth of the instruction RAM in 32-bit words
LINE_WORDS, ICACHE_LINE_SIZE/4 (4), beats per refill; must be a power of two, at least 2
ADDR_W, $clog2(MEM_WORDS) (10), RAM word-index width

Ports:
clk  in  1  system clock; all logic is on its rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  I-cache presents a refill request
req_ready  out  1  responder can accept a request
req_addr  in  XLEN  byte address of any byte inside the requested line
resp_valid  out  1  resp_data / resp_last / resp_err / resp_beat are valid
resp_ready  in  1  I-cache consumes the current beat
resp_data  out  XLEN  instruction word for the current beat
resp_beat  out  $clog2(LINE_WORDS)  word offset within the line of the current beat
resp_last  out  1  current beat is the final beat of the line
resp_err  out  1  request was out of range; the data is a substitute
load_we  in  1  preload write enable
load_addr  in  ADDR_W  preload word index
load_data  in  XLEN  preload word

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - FSM goes to IDLE; req_ready=1 from the following cycle.
  - resp_valid=0, resp_last=0, resp_err=0, resp_beat=0, resp_data=0.
  - Any in-flight line is dropped.
  - RAM contents are not cleared.
- FSM states: IDLE, RD, RSP.
- IDLE:
  - req_ready=1 and resp_valid=0.
  - On req_valid&&req_ready:
    - Latch the line base as req_addr with the low log2(ICACHE_LINE_SIZE) bits forced to 0.
    - Clear the beat counter.
    - Set err = (req_addr[XLEN-1:ADDR_W+2] != 0).
    - Go to RD.
- RD:
  - req_ready=0.
  - Present RAM read address {base_index, beat} (skipped when err).
  - Go to RSP.
- RSP:
  - resp_valid=1.
  - resp_data = RAM read output, or NOP_INSTR when err.
  - resp_beat = beat; resp_last = (beat == LINE_WORDS-1); resp_err = err.
  - Outputs hold stable while resp_ready=0; the RAM is not re-read.
  - On resp_ready && !resp_last: beat increments, go to RD.
  - On resp_ready && resp_last: go to IDLE.
- Timing:
  - First beat is visible in the second cycle after the request-accept edge.
  - Each subsequent beat follows one cycle after the previous handshake.
  - Full line with resp_ready held at 1 takes 2*LINE_WORDS cycles; req_ready returns the cycle after the last handshake.
- Beats are always returned in ascending order 0..LINE_WORDS-1. There is no critical-word-first.
- The beat counter wraps only via the return to IDLE; it never exceeds LINE_WORDS-1.
- RAM: one synchronous read port and one synchronous write port. load_we writes on the rising edge.
- Load/read collision (same word, same cycle): the read returns the old data (read-first). A preload during an active refill is legal; later beats see the new data.
- resp_valid never drops without a handshake, except on reset.
- req_valid while busy is ignored (req_ready=0); the requester must hold it.

Decomposition:
- riscv_pkg additions:
  - ICACHE_LINE_WORDS = ICACHE_LINE_SIZE/4
  - typedef enum refill_state_e {RF_IDLE, RF_RD, RF_RSP}
  - typedef struct packed refill_beat_t {data, beat, last, err}
- Sub-module imem_word_ram: MEM_WORDS x XLEN, one synchronous read port and one synchronous write port, read-first, no reset. The FSM, counter and error logic stay in imem_refill_responder.

Test Plan:
- Preload words 0..7 with 32'h1000_0000+i; request req_addr=32'h0000_0014, resp_ready=1.
  - Required: beats 32'h1000_0004..32'h1000_0007.
  - resp_beat 0..3; resp_last only on beat 3.
  - req_ready low for 8 cycles.
- Same request with resp_ready toggling 0/1 each cycle → resp_data, resp_beat and resp_last held stable while resp_ready=0; the four values are delivered in order with none lost.
- req_addr=32'h0000_1000 (out of range) → four beats of 32'h0000_0013 with resp_err=1; no RAM read is issued.
- load_we to word 5 with 32'hDEAD_BEEF in the same cycle the RD state reads word 5 → beat shows the old value; a later refill shows 32'hDEAD_BEEF.
- rst_n=0 during beat 2 → next cycle resp_valid=0 and req_ready=1; a new request to line 0 returns fresh beats starting at beat 0; RAM contents are unchanged.
- Back-to-back requests with req_valid held high → the second request is accepted the cycle after the first line's last handshake, and not before.

Source files
------------

// File: rtl/imem_refill_responder_pkg.sv
// Shared constants and types for the instruction-memory refill responder.
// Line geometry, the substitute instruction, FSM states and the beat record live here.
package imem_refill_responder_pkg;

    localparam int unsigned XLEN              = 32;
    localparam int unsigned IMEM_SIZE         = 1024;
    localparam int unsigned ICACHE_LINE_SIZE  = 16;
    localparam int unsigned ICACHE_LINE_WORDS = ICACHE_LINE_SIZE / 4;
    localparam int unsigned IMEM_ADDR_W       = $clog2(IMEM_SIZE);
    localparam int unsigned REFILL_BEAT_W     = $clog2(ICACHE_LINE_WORDS);

    // addi x0, x0, 0 -- returned in place of data for out-of-range refills
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RF_IDLE,
        RF_RD,
        RF_RSP
    } refill_state_e;

    typedef struct packed {
        logic [XLEN-1:0]          data;
        logic [REFILL_BEAT_W-1:0] beat;
        logic                     last;
        logic                     err;
    } refill_beat_t;

endpackage

// File: rtl/imem_refill_responder_if.sv
// Refill request/response handshake plus the RAM preload port.
// master = I-cache / loader side, slave = responder side.
interface imem_refill_if
    import imem_refill_responder_pkg::*;
#(
    parameter int unsigned DATA_W = XLEN,
    parameter int unsigned ADDR_W = IMEM_ADDR_W,
    parameter int unsigned BEAT_W = REFILL_BEAT_W
);

    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_addr;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic [BEAT_W-1:0] resp_beat;
    logic              resp_last;
    logic              resp_err;

    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;

    modport master (
        output req_valid, req_addr, resp_ready, load_we, load_addr, load_data,
        input  req_ready, resp_valid, resp_data, resp_beat, resp_last, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready, load_we, load_addr, load_data,
        output req_ready, resp_valid, resp_data, resp_beat, resp_last, resp_err
    );

endinterface

// File: rtl/imem_refill_responder_word_ram.sv
// Word-organised instruction RAM: one synchronous read port, one synchronous write port.
// Read-first on a same-address collision; contents are never reset.
module imem_word_ram #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [MEM_WORDS];
    logic [DATA_W-1:0] rdata_q;

    // The read samples the array before this edge's write lands.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_refill_responder.sv
// Memory-side responder for I-cache line refills: reads a line from the word RAM
// and returns it as ascending beats under a valid/ready handshake.
module imem_refill_responder
    import imem_refill_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS  = IMEM_SIZE,
    parameter int unsigned LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int unsigned ADDR_W     = $clog2(MEM_WORDS)
) (
    input  logic        clk,
    input  logic        rst_n,
    imem_refill_if.slave bus
);

    localparam int unsigned BEAT_W     = $clog2(LINE_WORDS);
    localparam int unsigned LINE_OFF_W = BEAT_W + 2;
    localparam int unsigned IDX_W      = ADDR_W - BEAT_W;

    refill_state_e     state_q, state_d;
    logic [IDX_W-1:0]  base_q, base_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              err_q, err_d;

    logic              rd_en;
    logic [XLEN-1:0]   rd_data;
    logic              is_last;
    refill_beat_t      rsp;

    imem_word_ram #(
        .MEM_WORDS (MEM_WORDS),
        .DATA_W    (XLEN),
        .ADDR_W    (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (bus.load_we),
        .waddr_i (bus.load_addr),
        .wdata_i (bus.load_data),
        .re_i    (rd_en),
        .raddr_i ({base_q, beat_q}),
        .rdata_o (rd_data)
    );

    assign is_last = (beat_q == BEAT_W'(LINE_WORDS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RF_IDLE;
            base_q  <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        beat_d        = beat_q;
        err_d         = err_q;
        rd_en         = 1'b0;
        bus.req_ready = 1'b0;

        unique case (state_q)
            RF_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    // Only the word-index bits of the line base are kept; anything above them flags err.
                    base_d  = bus.req_addr[ADDR_W+1:LINE_OFF_W];
                    beat_d  = '0;
                    err_d   = |bus.req_addr[XLEN-1:ADDR_W+2];
                    state_d = RF_RD;
                end
            end
            RF_RD: begin
                rd_en   = !err_q;
                state_d = RF_RSP;
            end
            RF_RSP: begin
                if (bus.resp_ready) begin
                    if (is_last) begin
                        state_d = RF_IDLE;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                        state_d = RF_RD;
                    end
                end
            end
            default: begin
                state_d = RF_IDLE;
            end
        endcase
    end

    // Response fields are zero outside RSP; the RAM output register holds the beat while stalled.
    always_comb begin
        rsp = '0;
        if (state_q == RF_RSP) begin
            rsp.data = err_q ? NOP_INSTR : rd_data;
            rsp.beat = beat_q;
            rsp.last = is_last;
            rsp.err  = err_q;
        end
    end

    assign bus.resp_valid = (state_q == RF_RSP);
    assign bus.resp_data  = rsp.data;
    assign bus.resp_beat  = rsp.beat;
    assign bus.resp_last  = rsp.last;
    assign bus.resp_err   = rsp.err;

endmodule

// File: tb/tb_imem_refill_responder.sv
// Directed bench for imem_refill_responder: in-order beats, stalls, out-of-range,
// load/read collision, mid-line reset and back-to-back requests.
module tb_imem_refill_responder;
    import imem_refill_responder_pkg::*;

    localparam int unsigned LW = 4;

    logic clk;
    logic rst_n;

    int n_vec;
    int n_err;

    logic [31:0] exp_w [LW];
    logic        exp_e;

    imem_refill_if #(.DATA_W(32), .ADDR_W(10), .BEAT_W(2)) ifc ();

    imem_refill_responder #(
        .MEM_WORDS  (1024),
        .LINE_WORDS (LW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic check_beat(input string tag, input int idx);
        check_val({tag, "_data"}, ifc.resp_data, exp_w[idx]);
        check_val({tag, "_beat"}, 32'(ifc.resp_beat), 32'(idx));
        check_val({tag, "_last"}, 32'(ifc.resp_last), 32'(idx == LW - 1));
        check_val({tag, "_err"},  32'(ifc.resp_err), 32'(exp_e));
    endtask

    task automatic set_exp(input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3, input logic e);
        exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2; exp_w[3] = w3;
        exp_e = e;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_resp_valid"}, 32'(ifc.resp_valid), 32'd0);
        check_val({tag, "_req_ready"},  32'(ifc.req_ready),  32'd1);
        check_val({tag, "_resp_data"},  ifc.resp_data,       32'd0);
        check_val({tag, "_resp_beat"},  32'(ifc.resp_beat),  32'd0);
        check_val({tag, "_resp_last"},  32'(ifc.resp_last),  32'd0);
        check_val({tag, "_resp_err"},   32'(ifc.resp_err),   32'd0);
    endtask

    // One complete refill; toggle stalls every other cycle, inject writes word 5 while beat 1 is read.
    task automatic refill(input logic [31:0] addr, input bit toggle, input bit inject, input string tag);
        int idx;
        int busy;
        bit done;
        bit injected;
        idx = 0; busy = 0; done = 1'b0; injected = 1'b0;
        @(negedge clk);
        check_val({tag, "_req_ready0"}, 32'(ifc.req_ready), 32'd1);
        ifc.req_valid  = 1'b1;
        ifc.req_addr   = addr;
        ifc.resp_ready = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            ifc.req_valid = 1'b0;
            ifc.load_we   = 1'b0;
            if (idx == LW && ifc.req_ready) begin
                done = 1'b1;
                break;
            end
            if (!ifc.req_ready) busy++;
            if (inject && !injected && idx == 1 && !ifc.resp_valid) begin
                ifc.load_we   = 1'b1;
                ifc.load_addr = 10'd5;
                ifc.load_data = 32'hDEAD_BEEF;
                injected      = 1'b1;
            end
            ifc.resp_ready = toggle ? cyc[0] : 1'b1;
            if (ifc.resp_valid && idx < LW) begin
                check_beat(tag, idx);
                if (ifc.resp_ready) idx++;
            end
        end
        ifc.resp_ready = 1'b0;
        check_val({tag, "_done"},  32'(done), 32'd1);
        check_val({tag, "_beats"}, 32'(idx),  32'(LW));
        if (!toggle) check_val({tag, "_busy_cycles"}, 32'(busy), 32'd8);
    endtask

    initial begin
        int found;
        int idx;
        int hi_cnt;
        int hi_at;
        n_vec = 0; n_err = 0;
        rst_n = 1'b0;
        ifc.req_valid = 1'b0; ifc.req_addr = '0; ifc.resp_ready = 1'b0;
        ifc.load_we = 1'b0; ifc.load_addr = '0; ifc.load_data = '0;
        exp_e = 1'b0;

        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ifc.load_we   = 1'b1;
            ifc.load_addr = 10'(i);
            ifc.load_data = 32'h1000_0000 + 32'(i);
        end
        @(negedge clk);
        ifc.load_we = 1'b0;

        set_exp(32'h1000_0004, 32'h1000_0005, 32'h1000_0006, 32'h1000_0007, 1'b0);
        refill(32'h0000_0014, 1'b0, 1'b0, "seq");
        refill(32'h0000_0014, 1'b1, 1'b0, "stall");

        set_exp(32'h13, 32'h13, 32'h13, 32'h13, 1'b1);
        refill(32'h0000_1000, 1'b0, 1'b0, "oor");

        set_exp(32'h1000_0004, 32'h1000_0005, 32'h1000_0006, 32'h1000_0007, 1'b0);
        refill(32'h0000_0014, 1'b0, 1'b1, "collide");
        set_exp(32'h1000_0004, 32'hDEAD_BEEF, 32'h1000_0006, 32'h1000_0007, 1'b0);
        refill(32'h0000_0014, 1'b0, 1'b0, "after_load");

        // Reset while beat 2 of line 0 is presented
        @(negedge clk);
        ifc.req_valid = 1'b1; ifc.req_addr = 32'h0; ifc.resp_ready = 1'b1;
        found = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            ifc.req_valid = 1'b0;
            if (ifc.resp_valid && ifc.resp_beat == 2'd2) begin
                found = 1;
                break;
            end
        end
        check_val("rst_reach_beat2", 32'(found), 32'd1);
        rst_n = 1'b0; ifc.resp_ready = 1'b0;
        @(negedge clk);
        check_idle_outputs("midline_rst");
        rst_n = 1'b1;

        set_exp(32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003, 1'b0);
        refill(32'h0000_0000, 1'b0, 1'b0, "post_rst");
        set_exp(32'h1000_0004, 32'hDEAD_BEEF, 32'h1000_0006, 32'h1000_0007, 1'b0);
        refill(32'h0000_0018, 1'b0, 1'b0, "ram_kept");

        // Back-to-back: req_valid held high across two line fills of line 0
        set_exp(32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003, 1'b0);
        @(negedge clk);
        ifc.req_valid = 1'b1; ifc.req_addr = 32'h0000_0008; ifc.resp_ready = 1'b1;
        idx = 0; hi_cnt = 0; hi_at = -1; found = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (hi_cnt > 0) ifc.req_valid = 1'b0;
            if (idx == 2 * LW && ifc.req_ready) begin
                found = 1;
                break;
            end
            if (ifc.req_ready) begin
                hi_cnt++;
                if (hi_at < 0) hi_at = cyc;
            end
            if (ifc.resp_valid && idx < 2 * LW) begin
                check_beat("b2b", idx % LW);
                idx++;
            end
        end
        ifc.req_valid = 1'b0; ifc.resp_ready = 1'b0;
        check_val("b2b_done",         32'(found),  32'd1);
        check_val("b2b_beats",        32'(idx),    32'(2 * LW));
        check_val("b2b_ready_pulses", 32'(hi_cnt), 32'd1);
        check_val("b2b_ready_cycle",  32'(hi_at),  32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
